arb_mux4_rr: RTL and testbench
==============================

# arb_mux4_rr

Round-robin arbiter and sequencer for the codebase's 4-bit 4:1 bus mux (`mux4bit41`), which this block instantiates internally. Four requesters each present a WIDTH-bit word and a request line. The block grants one requester at a time for a bounded tenure and drives the mux selects. It registers the selected word with a valid strobe and source tag for the downstream register file or display driver.

## Interface
Parameters:
- `WIDTH`, default 4: data width. Fixed at 4 while the internal mux is `mux4bit41`.
- `HOLD_CYCLES`, default 4: maximum tenure in clock cycles. Legal range 1..15.

Ports:
- `clk`  input  1: single clock. All state changes on its rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `req`  input  4: request lines. Bit i corresponds to input a/b/c/d for i = 0/1/2/3.
- `a`, `b`, `c`, `d`  input  WIDTH each: requester data words.
- `gnt`  output  4: one-hot grant, registered. All zero when idle.
- `s1`  output  1: mux select within a pair; 0 selects a/c, 1 selects b/d. Registered.
- `s2`  output  1: mux pair select; 0 selects the a/b pair, 1 selects the c/d pair. Registered.
- `y`  output  WIDTH: registered mux output.
- `y_valid`  output  1: `y` holds a word captured from a requesting owner.
- `y_src`  output  2: index of the source of `y`, equal to {s2,s1} at capture.
- `busy`  output  1: FSM is in GRANT.

## Operation
Reset (asynchronous, while `rst_n`=0):
- `gnt`=0, `s1`=`s2`=0, `y`=0, `y_valid`=0, `y_src`=0, `busy`=0.
- Last-owner pointer `last`=3, so requester 0 wins first.
- Tenure counter `cnt`=0. State = IDLE.

Index encoding: owner index i maps to {s2,s1}. 0→a, 1→b, 2→c, 3→d.

Round-robin pick: the first i with `req[i]`=1, searching `last`+1, `last`+2, … mod 4.

FSM:
- IDLE:
  - If `req`≠0, pick winner w. Next cycle: `gnt`=1<<w, {s2,s1}=w, `last`=w, `cnt`=0, state = GRANT.
  - Otherwise stay in IDLE.
- GRANT, owner o. Each edge:
  - If `req[o]`=1 and `cnt` < HOLD_CYCLES−1: `cnt`++ and stay.
  - Tenure ends when `req[o]`=0 or `cnt` = HOLD_CYCLES−1.
  - On tenure end, run the pick using `last`=o. If a winner exists (possibly o itself when it is the only requester), grant it at that same edge with `cnt`=0 and no idle gap.
  - On tenure end with no winner: `gnt`=0, state = IDLE. `s1`/`s2` hold their last value.

Capture, every edge:
- `y` <= mux output.
- `y_src` <= {s2,s1}.
- `y_valid` <= |(`gnt` & `req`).
- `y` and `y_src` update every cycle. Only `y_valid` qualifies them.

Boundary rules:
- HOLD_CYCLES=1: the grant rotates every cycle among the active requesters.
- `req` bits of non-owners never preempt an active tenure.
- The owner dropping `req` ends its tenure at that edge. The word sampled in that cycle is flagged invalid.
- `rst_n` asserted mid-tenure: all outputs return to reset values immediately. After release, arbitration restarts from requester 0.

## Timing
- Request to grant: 1 cycle. `req` sampled at edge N gives `gnt`/selects valid after edge N.
- Grant to data: 1 cycle. The word selected in the cycle after edge N appears on `y` with `y_valid`=1 after edge N+1.
- Owner switch: zero-gap. The new `gnt` and selects take effect at the edge that ends the old tenure.
- Max tenure: exactly HOLD_CYCLES cycles of `gnt` per grant.
- Worst-case wait for a continuously requesting port: 3·HOLD_CYCLES cycles.
- Throughput: one valid word per cycle while any owner requests.

## Test plan
- Reset check: hold `rst_n`=0 with `req`=4'hF. Required: `gnt`=0, `y`=0, `y_valid`=0, `busy`=0. After release, the first grant is `gnt`=4'b0001 with {s2,s1}=0.
- Single requester: `req`=4'b0100, `c`=4'hA, HOLD_CYCLES=4. Required: `gnt`=4'b0100 after 1 cycle. `y`=4'hA, `y_src`=2, `y_valid`=1 from the next cycle, continuously. Re-grant after 4 cycles with no gap.
- Full contention: `req`=4'hF, `a..d`=1,2,3,4. Required: grants rotate 0→1→2→3→0, 4 cycles each. The `y` sequence is 1×4, 2×4, 3×4, 4×4.
- Early release: owner 1 drops `req` after 2 granted cycles while `req[3]`=1. Required: `gnt` moves to 4'b1000 at that edge. One `y_valid`=0 capture for the dropped cycle.
- Idle return: all `req` drop. Required: `gnt`=0 and `busy`=0 next cycle, then `y_valid`=0 one cycle later. `s1`/`s2` hold their values.
- Mid-tenure reset: assert `rst_n`=0 asynchronously during owner 2's tenure. Required: outputs clear without a clock edge. After release with `req`=4'hF, the first grant is 0.

Source files
------------

// File: rtl/arb_mux4_rr.sv
// ---------------------------------------------------------------------------
// mux4bit41
//   Plain 4-bit 4:1 bus mux. s2 chooses the pair (a/b or c/d) and s1 chooses
//   the word within that pair.
//
//   Ports:
//     a, b, c, d : 4-bit data words
//     s1         : 0 selects a/c, 1 selects b/d
//     s2         : 0 selects the a/b pair, 1 selects the c/d pair
//     y          : selected word (combinational)
// ---------------------------------------------------------------------------
module mux4bit41 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] c,
    input  logic [3:0] d,
    input  logic       s1,
    input  logic       s2,
    output logic [3:0] y
);

    // Two-level select: first resolve the word inside each pair, then
    // choose between the two pair results.
    logic [3:0] pair_ab;
    logic [3:0] pair_cd;

    always_comb begin
        pair_ab = s1 ? b : a;
        pair_cd = s1 ? d : c;
        y       = s2 ? pair_cd : pair_ab;
    end

endmodule

// ---------------------------------------------------------------------------
// arb_mux4_rr
//   Round-robin arbiter that owns the selects of a mux4bit41. One of four
//   requesters is granted at a time for at most HOLD_CYCLES cycles; the
//   selected word is registered together with a valid strobe and source tag.
//
//   Parameters:
//     WIDTH       : data width, fixed at 4 by the internal mux4bit41
//     HOLD_CYCLES : maximum tenure in cycles, 1..15
//
//   Ports:
//     clk        : clock, all state changes on the rising edge
//     rst_n      : asynchronous active-low reset
//     req[3:0]   : request lines, bit i belongs to a/b/c/d for i = 0/1/2/3
//     a, b, c, d : requester data words
//     gnt[3:0]   : registered one-hot grant, zero when idle
//     s1, s2     : registered mux selects, {s2,s1} is the owner index
//     y          : registered mux output
//     y_valid    : y was captured from an owner that was still requesting
//     y_src      : {s2,s1} at the time y was captured
//     busy       : arbiter is in the GRANT state
// ---------------------------------------------------------------------------
module arb_mux4_rr #(
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [3:0]       gnt,
    output logic             s1,
    output logic             s2,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic [1:0]       y_src,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Last tenure count value before the grant has to be released.
    localparam logic [3:0] CNT_LAST = 4'(HOLD_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [1:0] last;
    logic [1:0] last_next;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic [3:0] gnt_next;
    logic       s1_next;
    logic       s2_next;

    logic       pick_valid;
    logic [1:0] pick_idx;
    logic       tenure_end;
    logic [WIDTH-1:0] mux_y;

    // The mux is steered directly by the registered selects, so the word
    // seen here always belongs to the current owner (or the last one when
    // idle, since the selects hold their value).
    mux4bit41 u_mux (
        .a  (a),
        .b  (b),
        .c  (c),
        .d  (d),
        .s1 (s1),
        .s2 (s2),
        .y  (mux_y)
    );

    // Round-robin search starting just after the last owner. Scanning the
    // offsets from farthest (4, i.e. last itself) to nearest (1) lets the
    // nearest active requester overwrite earlier hits, so the final value is
    // the first one in round-robin order. The current owner only wins again
    // when nobody else is requesting.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = last;
        for (int k = 4; k >= 1; k--) begin
            if (req[last + 2'(k)]) begin
                pick_valid = 1'b1;
                pick_idx   = last + 2'(k);
            end
        end
    end

    // A tenure ends either because the owner let go of its request or
    // because it has used up its full allotment of cycles. The owner is
    // always 'last', since a grant updates the pointer at the same edge.
    always_comb begin
        tenure_end = (req[last] == 1'b0) || (cnt == CNT_LAST);
    end

    // Next-state and next-output logic. Everything defaults to holding its
    // value; the selects in particular are never cleared on return to IDLE.
    always_comb begin
        state_next = state;
        last_next  = last;
        cnt_next   = cnt;
        gnt_next   = gnt;
        s1_next    = s1;
        s2_next    = s2;

        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next = GRANT;
                    last_next  = pick_idx;
                    cnt_next   = 4'd0;
                    gnt_next   = 4'b0001 << pick_idx;
                    s1_next    = pick_idx[0];
                    s2_next    = pick_idx[1];
                end
            end

            GRANT: begin
                if (!tenure_end) begin
                    cnt_next = cnt + 4'd1;
                end else if (pick_valid) begin
                    // Hand over at this very edge so there is no idle gap.
                    last_next = pick_idx;
                    cnt_next  = 4'd0;
                    gnt_next  = 4'b0001 << pick_idx;
                    s1_next   = pick_idx[0];
                    s2_next   = pick_idx[1];
                end else begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                    gnt_next   = 4'b0000;
                end
            end

            default: begin
                state_next = IDLE;
                gnt_next   = 4'b0000;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Arbiter state register. The pointer resets to 3 so that requester 0
    // is the first one considered after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 2'd3;
            cnt   <= 4'd0;
            gnt   <= 4'b0000;
            s1    <= 1'b0;
            s2    <= 1'b0;
        end else begin
            state <= state_next;
            last  <= last_next;
            cnt   <= cnt_next;
            gnt   <= gnt_next;
            s1    <= s1_next;
            s2    <= s2_next;
        end
    end

    // Output capture runs every cycle regardless of state. The word is only
    // marked valid when the granted requester was still asking for the bus
    // in the cycle the word was sampled, so a dropped request produces one
    // invalid capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y       <= '0;
            y_src   <= 2'd0;
            y_valid <= 1'b0;
        end else begin
            y       <= mux_y;
            y_src   <= {s2, s1};
            y_valid <= |(gnt & req);
        end
    end

    // Busy simply reflects the registered state.
    always_comb begin
        busy = (state == GRANT);
    end

endmodule

// File: tb/tb_arb_mux4_rr.sv
// ---------------------------------------------------------------------------
// tb_arb_mux4_rr
//   Directed bench for arb_mux4_rr. A HOLD_CYCLES=4 instance carries the main
//   scenarios; a HOLD_CYCLES=1 instance shares the same inputs and is used
//   for the per-cycle rotation case.
// ---------------------------------------------------------------------------
module tb_arb_mux4_rr;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] a, b, c, d;

    logic [3:0] gnt;
    logic       s1, s2;
    logic [3:0] y;
    logic       y_valid;
    logic [1:0] y_src;
    logic       busy;

    logic [3:0] gnt1;
    logic       s1_1, s2_1;
    logic [3:0] y1;
    logic       y_valid1;
    logic [1:0] y_src1;
    logic       busy1;

    int errors;
    int checks;

    arb_mux4_rr #(.WIDTH(4), .HOLD_CYCLES(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .gnt     (gnt),
        .s1      (s1),
        .s2      (s2),
        .y       (y),
        .y_valid (y_valid),
        .y_src   (y_src),
        .busy    (busy)
    );

    arb_mux4_rr #(.WIDTH(4), .HOLD_CYCLES(1)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .gnt     (gnt1),
        .s1      (s1_1),
        .s2      (s2_1),
        .y       (y1),
        .y_valid (y_valid1),
        .y_src   (y_src1),
        .busy    (busy1)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge, where outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Set the request and data inputs in one go.
    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] da,
                                 input logic [3:0] db, input logic [3:0] dc,
                                 input logic [3:0] dd);
        req = r;
        a   = da;
        b   = db;
        c   = dc;
        d   = dd;
    endtask

    // Pulse reset across one falling edge so release never lands on the
    // rising edge.
    task automatic doReset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        applyStimulus(4'hF, 4'h1, 4'h2, 4'h3, 4'h4);

        // ---- Reset state with all requests active
        tick();
        tick();
        checkOutput("rst_gnt",     gnt,     0);
        checkOutput("rst_y",       y,       0);
        checkOutput("rst_y_valid", y_valid, 0);
        checkOutput("rst_busy",    busy,    0);
        checkOutput("rst_sel",     {s2, s1}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("rst_first_gnt", gnt,      4'b0001);
        checkOutput("rst_first_sel", {s2, s1}, 0);
        checkOutput("rst_first_busy", busy,    1);

        // ---- Single requester c: continuous grant, re-granted with no gap
        applyStimulus(4'b0100, 4'h1, 4'h2, 4'hA, 4'h4);
        doReset();
        tick();
        checkOutput("single_gnt0", gnt, 4'b0100);
        for (int k = 0; k < 8; k++) begin
            tick();
            checkOutput($sformatf("single_gnt_%0d", k),   gnt,     4'b0100);
            checkOutput($sformatf("single_y_%0d", k),     y,       4'hA);
            checkOutput($sformatf("single_src_%0d", k),   y_src,   2);
            checkOutput($sformatf("single_valid_%0d", k), y_valid, 1);
            checkOutput($sformatf("single_busy_%0d", k),  busy,    1);
        end

        // ---- Full contention: 4 cycles per owner, 0 -> 1 -> 2 -> 3 -> 0
        applyStimulus(4'hF, 4'h1, 4'h2, 4'h3, 4'h4);
        doReset();
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k <= 17)
                checkOutput($sformatf("rr_gnt_%0d", k), gnt, 4'b0001 << (((k - 1) / 4) % 4));
            if (k >= 2) begin
                checkOutput($sformatf("rr_y_%0d", k),     y,       (((k - 2) / 4) % 4) + 1);
                checkOutput($sformatf("rr_src_%0d", k),   y_src,   ((k - 2) / 4) % 4);
                checkOutput($sformatf("rr_valid_%0d", k), y_valid, 1);
            end
        end

        // ---- Early release of owner 1 while requester 3 waits, then idle
        applyStimulus(4'b1010, 4'h1, 4'h2, 4'h3, 4'h4);
        doReset();
        tick();
        checkOutput("early_gnt1", gnt, 4'b0010);
        tick();
        checkOutput("early_gnt2",   gnt,     4'b0010);
        checkOutput("early_valid2", y_valid, 1);
        checkOutput("early_y2",     y,       4'h2);
        req = 4'b1000;
        tick();
        checkOutput("early_switch_gnt", gnt,      4'b1000);
        checkOutput("early_switch_sel", {s2, s1}, 3);
        checkOutput("early_drop_valid", y_valid,  0);
        tick();
        checkOutput("early_new_valid", y_valid, 1);
        checkOutput("early_new_y",     y,       4'h4);
        checkOutput("early_new_src",   y_src,   3);
        req = 4'b0000;
        tick();
        checkOutput("idle_gnt",  gnt,      0);
        checkOutput("idle_busy", busy,     0);
        checkOutput("idle_sel",  {s2, s1}, 3);
        tick();
        checkOutput("idle_valid",     y_valid,  0);
        checkOutput("idle_sel_hold",  {s2, s1}, 3);
        checkOutput("idle_gnt_hold",  gnt,      0);

        // ---- Asynchronous reset in the middle of owner 2's tenure
        applyStimulus(4'b0100, 4'h1, 4'h2, 4'h3, 4'h4);
        doReset();
        tick();
        tick();
        checkOutput("midrst_pre_gnt", gnt, 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_gnt",   gnt,      0);
        checkOutput("midrst_sel",   {s2, s1}, 0);
        checkOutput("midrst_y",     y,        0);
        checkOutput("midrst_valid", y_valid,  0);
        checkOutput("midrst_src",   y_src,    0);
        checkOutput("midrst_busy",  busy,     0);
        req = 4'hF;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("midrst_first_gnt", gnt, 4'b0001);

        // ---- HOLD_CYCLES=1: rotation every cycle among active requesters
        applyStimulus(4'b0101, 4'h1, 4'h2, 4'h3, 4'h4);
        doReset();
        for (int k = 1; k <= 6; k++) begin
            tick();
            checkOutput($sformatf("h1_gnt_%0d", k), gnt1, (k % 2 == 1) ? 4'b0001 : 4'b0100);
            if (k >= 2)
                checkOutput($sformatf("h1_y_%0d", k), y1, (k % 2 == 0) ? 4'h1 : 4'h3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
